// File: rtl/execute_mem_agu_pipe_pkg.sv
// Shared definitions for the execute memory-path AGU: size and segment encodings,
// request/result layouts and the alignment rule.
package mem_agu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [2:0] SEG_KSEG0 = 3'b100;
  localparam logic [2:0] SEG_KSEG1 = 3'b101;

  // Layout widths of the default configuration (32-bit address, 6-bit ROB tag).
  localparam int AGU_ADDR_W = 32;
  localparam int AGU_TAG_W  = 6;

  typedef struct packed {
    logic [AGU_TAG_W-1:0]  tag;
    logic [AGU_ADDR_W-1:0] v_addr;
    logic [1:0]            size;
    logic                  store;
  } agu_req_t;

  typedef struct packed {
    logic [AGU_TAG_W-1:0]  tag;
    logic [AGU_ADDR_W-1:0] v_addr;
    logic [AGU_ADDR_W-1:0] p_addr;
    logic                  uncached;
    logic                  misalign;
    logic                  store;
    logic [1:0]            size;
  } agu_res_t;

  // The reserved size code 3 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] low);
    logic bad;
    bad = 1'b0;
    if (size == SIZE_BYTE)      bad = 1'b0;
    else if (size == SIZE_HALF) bad = low[0];
    else                        bad = (low != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/execute_mem_agu_xlate.sv
// Combinational fixed-segment translation and alignment check for the AGU.
// Alignment checking is built only when EXECUTE_MEM_AGU_ALIGN_CHECK_EN is defined.
module execute_mem_agu_xlate
  import mem_agu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] v_addr_i,
  input  logic [1:0]        size_i,
  output logic [ADDR_W-1:0] p_addr_o,
  output logic              uncached_o,
  output logic              misalign_o
);

  logic [2:0] seg;
  assign seg = v_addr_i[ADDR_W-1 -: 3];

  // kseg0/kseg1 are unmapped windows onto the low physical space.
  always_comb begin
    p_addr_o   = v_addr_i;
    uncached_o = 1'b0;
    if ((seg == SEG_KSEG0) || (seg == SEG_KSEG1)) begin
      p_addr_o = {3'b000, v_addr_i[ADDR_W-4:0]};
    end
    if (seg == SEG_KSEG1) begin
      uncached_o = 1'b1;
    end
  end

`ifdef EXECUTE_MEM_AGU_ALIGN_CHECK_EN
  assign misalign_o = is_misaligned(size_i, v_addr_i[1:0]);
`else
  // Unaligned accesses pass through; the LSU splits them.
  logic unused_size;
  assign unused_size = ^size_i;
  assign misalign_o  = 1'b0;
`endif

endmodule

// File: rtl/execute_mem_agu_pipe.sv
// Two-stage load/store AGU: S1 adds base + sign-extended immediate, S2 holds the
// translated result. Optional alignment check: EXECUTE_MEM_AGU_ALIGN_CHECK_EN.
module execute_mem_agu_pipe
  import mem_agu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 16,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [ADDR_W-1:0] i_src0_value,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [1:0]        i_size,
  input  logic              i_store,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [TAG_W-1:0]  o_tag,
  output logic [ADDR_W-1:0] o_v_addr,
  output logic [ADDR_W-1:0] o_p_addr,
  output logic              o_uncached,
  output logic              o_misalign,
  output logic              o_store,
  output logic [1:0]        o_size
);

  // Handshake: a transfer happens on an edge where valid & ready are both high;
  // ready never depends on the same side's valid, and flush overrides every transfer.
  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [TAG_W-1:0]  s1_tag_q;
  logic [ADDR_W-1:0] s1_v_addr_q, s1_v_addr_d;
  logic [1:0]        s1_size_q;
  logic              s1_store_q;

  logic [TAG_W-1:0]  s2_tag_q;
  logic [ADDR_W-1:0] s2_v_addr_q, s2_p_addr_q;
  logic              s2_uncached_q, s2_misalign_q, s2_store_q;
  logic [1:0]        s2_size_q;

  logic              s2_adv, in_fire, s12_fire;
  logic [ADDR_W-1:0] xl_p_addr;
  logic              xl_uncached, xl_misalign;

  assign s2_adv   = !s2_valid_q || i_ready;
  assign o_ready  = !s1_valid_q || s2_adv;
  assign in_fire  = i_valid && o_ready && !i_flush;
  assign s12_fire = s1_valid_q && s2_adv && !i_flush;

  assign s1_v_addr_d = i_src0_value + ADDR_W'($signed(i_imm));

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (i_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      s1_valid_d = in_fire || (s1_valid_q && !s2_adv);
      if (s2_adv) s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_tag_q    <= '0;
      s1_v_addr_q <= '0;
      s1_size_q   <= '0;
      s1_store_q  <= 1'b0;
    end else if (in_fire) begin
      s1_tag_q    <= i_tag;
      s1_v_addr_q <= s1_v_addr_d;
      s1_size_q   <= i_size;
      s1_store_q  <= i_store;
    end
  end

  execute_mem_agu_xlate #(
    .ADDR_W(ADDR_W)
  ) u_xlate (
    .v_addr_i  (s1_v_addr_q),
    .size_i    (s1_size_q),
    .p_addr_o  (xl_p_addr),
    .uncached_o(xl_uncached),
    .misalign_o(xl_misalign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_tag_q      <= '0;
      s2_v_addr_q   <= '0;
      s2_p_addr_q   <= '0;
      s2_uncached_q <= 1'b0;
      s2_misalign_q <= 1'b0;
      s2_store_q    <= 1'b0;
      s2_size_q     <= '0;
    end else if (s12_fire) begin
      s2_tag_q      <= s1_tag_q;
      s2_v_addr_q   <= s1_v_addr_q;
      s2_p_addr_q   <= xl_p_addr;
      s2_uncached_q <= xl_uncached;
      s2_misalign_q <= xl_misalign;
      s2_store_q    <= s1_store_q;
      s2_size_q     <= s1_size_q;
    end
  end

  assign o_valid    = s2_valid_q;
  assign o_tag      = s2_tag_q;
  assign o_v_addr   = s2_v_addr_q;
  assign o_p_addr   = s2_p_addr_q;
  assign o_uncached = s2_uncached_q;
  assign o_misalign = s2_misalign_q;
  assign o_store    = s2_store_q;
  assign o_size     = s2_size_q;

endmodule

// File: tb/tb_execute_mem_agu_pipe.sv
// Self-checking bench for execute_mem_agu_pipe: directed vectors, a result-queue
// model checked every cycle o_valid is high, and literal spot checks.
module tb_execute_mem_agu_pipe;

  localparam int RW = 75;
`ifdef EXECUTE_MEM_AGU_ALIGN_CHECK_EN
  localparam logic MIS_EXP = 1'b1;
`else
  localparam logic MIS_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [5:0]  i_tag = '0;
  logic [31:0] i_src0_value = '0;
  logic [15:0] i_imm = '0;
  logic [1:0]  i_size = '0;
  logic        i_store = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [5:0]  o_tag;
  logic [31:0] o_v_addr, o_p_addr;
  logic        o_uncached, o_misalign, o_store;
  logic [1:0]  o_size;

  int total = 0;
  int bad = 0;
  logic [RW-1:0] exp_q[$];
  logic [5:0]    got_tags[$];

  execute_mem_agu_pipe dut (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_tag(i_tag), .i_src0_value(i_src0_value), .i_imm(i_imm), .i_size(i_size),
    .i_store(i_store), .o_valid(o_valid), .i_ready(i_ready), .o_tag(o_tag),
    .o_v_addr(o_v_addr), .o_p_addr(o_p_addr), .o_uncached(o_uncached),
    .o_misalign(o_misalign), .o_store(o_store), .o_size(o_size)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Result layout: {tag, v_addr, p_addr, uncached, misalign, store, size}.
  function automatic logic [RW-1:0] model(input logic [5:0] tag, input logic [31:0] src,
                                          input logic [15:0] imm, input logic [1:0] size,
                                          input logic store);
    logic [31:0] v, p;
    logic        unc, mis;
    v   = src + {{16{imm[15]}}, imm};
    unc = (v >= 32'hA000_0000) && (v < 32'hC000_0000);
    p   = ((v >= 32'h8000_0000) && (v < 32'hC000_0000)) ? (v - 32'h8000_0000) % 32'h2000_0000 : v;
    mis = 1'b0;
`ifdef EXECUTE_MEM_AGU_ALIGN_CHECK_EN
    if (size == 2'd1) mis = (v % 2) != 0;
    else if (size >= 2'd2) mis = (v % 4) != 0;
`endif
    return {tag, v, p, unc, mis, store, size};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_result: got tag %h with o_valid required no pending result", o_tag);
        end else begin
          check("result", {o_tag, o_v_addr, o_p_addr, o_uncached, o_misalign, o_store, o_size}, exp_q[0]);
          if (i_ready && !i_flush) begin
            got_tags.push_back(o_tag);
            void'(exp_q.pop_front());
          end
        end
      end
      if (i_flush) exp_q.delete();
      else if (i_valid && o_ready) exp_q.push_back(model(i_tag, i_src0_value, i_imm, i_size, i_store));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [5:0] tag, input logic [31:0] src, input logic [15:0] imm,
                      input logic [1:0] size, input logic store);
    logic acc;
    acc = 1'b0;
    i_valid = 1'b1; i_tag = tag; i_src0_value = src; i_imm = imm; i_size = size; i_store = store;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("accept_timeout", {127'd0, acc}, 128'd1);
    i_valid = 1'b0;
  endtask

  task automatic lit(input logic [5:0] tag, input logic [31:0] src, input logic [15:0] imm,
                     input logic [1:0] size, input logic store, input logic [31:0] ev,
                     input logic [31:0] ep, input logic eunc, input logic emis);
    send(tag, src, imm, size, store);
    check("latency_early", o_valid, 0);
    @(posedge clk); #1;
    check("latency_valid", o_valid, 1);
    check("lit_tag", o_tag, tag);
    check("lit_v_addr", o_v_addr, ev);
    check("lit_p_addr", o_p_addr, ep);
    check("lit_uncached", o_uncached, eunc);
    check("lit_misalign", o_misalign, emis);
    check("lit_store", o_store, store);
    check("lit_size", o_size, size);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [RW-1:0] m;

    // model pinned against hand-computed results
    m = model(6'd1, 32'h0000_1000, 16'hFFFC, 2'd2, 1'b0);
    check("model_basic_v", m[68:37], 32'h0000_0FFC);
    m = model(6'd2, 32'hBFC0_0000, 16'h0010, 2'd2, 1'b0);
    check("model_kseg1_p", m[36:5], 32'h1FC0_0010);
    check("model_kseg1_unc", m[4], 1);
    m = model(6'd3, 32'hFFFF_FFFC, 16'h0008, 2'd0, 1'b0);
    check("model_wrap_v", m[68:37], 32'h0000_0004);

    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_ready", o_ready, 1);
    check("rst_o_data", {o_tag, o_v_addr, o_p_addr, o_uncached, o_misalign, o_store, o_size}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    lit(6'd1, 32'h0000_1000, 16'hFFFC, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0000_0FFC, 1'b0, 1'b0);
    lit(6'd2, 32'hBFC0_0000, 16'h0010, 2'd2, 1'b0, 32'hBFC0_0010, 32'h1FC0_0010, 1'b1, 1'b0);
    lit(6'd3, 32'h8000_0100, 16'h0000, 2'd2, 1'b1, 32'h8000_0100, 32'h0000_0100, 1'b0, 1'b0);
    lit(6'd4, 32'h0000_0000, 16'h0003, 2'd1, 1'b1, 32'h0000_0003, 32'h0000_0003, 1'b0, MIS_EXP);
    lit(6'd5, 32'hFFFF_FFFC, 16'h0008, 2'd0, 1'b0, 32'h0000_0004, 32'h0000_0004, 1'b0, 1'b0);
    lit(6'd6, 32'hA000_0002, 16'h0000, 2'd3, 1'b0, 32'hA000_0002, 32'h0000_0002, 1'b1, MIS_EXP);

    // back-to-back with a 3-cycle downstream stall after the first result
    got_tags.delete();
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(6'(10 + i), 32'h0000_0100 * (i + 1), 16'(i * 2), 2'(i), 1'(i % 2));
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          if (o_valid) break;
        end
        i_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("stall_o_ready", o_ready, 0);
          check("stall_hold_tag", o_tag, 10);
          check("stall_hold_valid", o_valid, 1);
          @(posedge clk); #1;
        end
        i_ready = 1'b1;
      end
    join
    drain();
    check("b2b_count", got_tags.size(), 4);
    for (int i = 0; i < 4 && i < got_tags.size(); i++) check("b2b_order", got_tags[i], 10 + i);

    // flush with both stages full and a third request presented
    i_ready = 1'b0;
    send(6'd20, 32'h0000_2000, 16'h0004, 2'd2, 1'b0);
    send(6'd21, 32'h0000_3000, 16'h0008, 2'd2, 1'b1);
    check("flush_pre_valid", o_valid, 1);
    check("flush_pre_ready", o_ready, 0);
    got_tags.delete();
    i_valid = 1'b1; i_tag = 6'd22; i_src0_value = 32'h0000_4000; i_imm = 16'h0; i_size = 2'd2;
    i_ready = 1'b1; i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    check("flush_o_valid", o_valid, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("flush_quiet", o_valid, 0);
    end
    check("flush_no_results", got_tags.size(), 0);
    lit(6'd23, 32'h0000_5000, 16'hFFFF, 2'd0, 1'b1, 32'h0000_4FFF, 32'h0000_4FFF, 1'b0, 1'b0);

    // asynchronous reset with a result waiting
    i_ready = 1'b0;
    send(6'd30, 32'hA000_1000, 16'h0001, 2'd1, 1'b1);
    @(posedge clk); #1;
    check("arst_pre_valid", o_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_o_valid", o_valid, 0);
    check("arst_o_data", {o_tag, o_v_addr, o_p_addr, o_uncached, o_misalign, o_store, o_size}, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_o_ready", o_ready, 1);
    check("arst_still_idle", o_valid, 0);
    i_ready = 1'b1;
    @(posedge clk); #1;
    lit(6'd31, 32'h8000_0000, 16'h8000, 2'd2, 1'b0, 32'h7FFF_8000, 32'h7FFF_8000, 1'b0, 1'b0);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_mem_agu_pipe.md
Name: execute_mem_agu_pipe

Overview:
- Pipelined, parametrised load/store address generation unit for the execute memory path.
- Computes effective virtual address = base + sign-extended immediate, then applies the fixed kseg0/kseg1 translation and checks alignment.
- Two registered stages with valid/ready handshakes on both sides and a pipeline flush.
- Sits between mem issue queue and the LSU/dcache request port.

Parameters:
- ADDR_W, 32, virtual/physical address width (>= 32; kseg decode uses the top 3 bits).
- IMM_W, 16, immediate offset width (<= ADDR_W); sign bit is i_imm[IMM_W-1].
- TAG_W, 6, width of the instruction tag (ROB index) carried alongside.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous kill of all in-flight entries.
- i_valid  in  1  request valid.
- o_ready  out  1  AGU can accept the request this cycle.
- i_tag  in  TAG_W  instruction tag.
- i_src0_value  in  ADDR_W  base register value.
- i_imm  in  IMM_W  offset immediate.
- i_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word).
- i_store  in  1  1=store, 0=load.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_tag  out  TAG_W  tag of the result.
- o_v_addr  out  ADDR_W  effective virtual address.
- o_p_addr  out  ADDR_W  physical address.
- o_uncached  out  1  address lies in kseg1.
- o_misalign  out  1  address error (AdEL/AdES, selected by o_store).
- o_store  out  1  store flag passthrough.
- o_size  out  2  size passthrough.

Behaviour:
- Reset (async, active-high):
  - s1_valid = s2_valid = 0, so o_valid = 0.
  - All data registers, and therefore all data outputs, reset to 0.
- Handshake and stage movement:
  - s2_adv = !s2_valid | i_ready.
  - o_ready = !s1_valid | s2_adv. o_ready is combinational and does not depend on i_valid.
  - Input transfer: i_valid & o_ready. S1 loads tag, size, store and v_addr.
  - S1 to S2 transfer: s1_valid & s2_adv.
  - Output transfer: o_valid & i_ready.
- Latency and throughput:
  - Accept at edge N produces o_valid after edge N+1 (2-cycle latency).
  - One request per cycle sustained while i_ready = 1.
- Stall: while o_valid & !i_ready, all S2 outputs hold stable. S1 holds. o_ready = !s1_valid.
- Stage 1 arithmetic: v_addr = i_src0_value + sext(i_imm to ADDR_W), modulo 2^ADDR_W. Carry out is discarded: 0xFFFF_FFFC + 8 = 0x0000_0004.
- Stage 2 translation and alignment, computed from the S1 register:
  - seg = v_addr[ADDR_W-1 -: 3].
  - seg = 3'b100 (kseg0): p_addr = v_addr with the top 3 bits cleared; uncached = 0.
  - seg = 3'b101 (kseg1): p_addr = v_addr with the top 3 bits cleared; uncached = 1.
  - Any other segment: p_addr = v_addr; uncached = 0.
  - misalign = (size==1 & v[0]) | (size>=2 & |v[1:0]).
- Flush: i_flush = 1 at an edge clears s1_valid and s2_valid.
  - A request presented in the same cycle is discarded, even though o_ready may be 1.
  - Flush has priority over every transfer, including the output transfer that same cycle.
  - Data registers need not clear.
- Data registers load only on their transfer. Valid bits toggle only as described above.

Optional Feature:
- Macro: EXECUTE_MEM_AGU_ALIGN_CHECK_EN.
- Defined: o_misalign is computed as above.
- Undefined: o_misalign is tied to 0, and the alignment logic is not instantiated. Accesses pass unchanged; the LSU handles splitting.

Decomposition:
- Shared package (mem_agu_pkg):
  - Size encodings SIZE_BYTE/HALF/WORD.
  - Segment constants SEG_KSEG0 = 3'b100 and SEG_KSEG1 = 3'b101.
  - Request/result struct typedefs parametrised by ADDR_W/TAG_W.
- Sub-module: execute_mem_agu_xlate.
  - Combinational: v_addr and size in; p_addr, uncached and misalign out.
  - Instantiated in S2 so it can be reused by a future TLB-backed AGU.

Test Plan:
- Basic add: src0 = 0x0000_1000, imm = 0xFFFC, size = 2, load → 2 cycles later o_v_addr = 0x0000_0FFC, o_p_addr = 0x0000_0FFC, o_uncached = 0, o_misalign = 0.
- Kseg1 uncached: src0 = 0xBFC0_0000, imm = 0x0010 → o_p_addr = 0x1FC0_0010, o_uncached = 1. With src0 = 0x8000_0100 → o_p_addr = 0x0000_0100, o_uncached = 0.
- Misalign (macro defined): size = 1, v_addr = 0x0000_0003, store → o_misalign = 1, o_store = 1. With the macro undefined → o_misalign = 0.
- Back-to-back with stall: 4 requests on consecutive cycles, i_ready held 0 for 3 cycles after the first result:
  - Outputs hold stable and o_ready drops once both stages are full.
  - All 4 results are then delivered in order by tag, with none lost or duplicated.
- Flush mid-flight: both stages full and a third request presented with i_flush = 1 → next cycle o_valid = 0, no result for any of the 3 tags, and a subsequent request completes normally.
- Async reset mid-operation: reset asserted between edges with o_valid = 1 → o_valid and all outputs go to 0 immediately, and o_ready = 1 after release.
